// File: rtl/sprite_compositor.sv
// Sprite compositor: chroma-keyed merge of two sprite streams over a background stream,
// timing delay line matched to sprite latency, and per-frame sprite overlap reporting.
module sprite_compositor #(
  parameter int unsigned SPRITE_LATENCY = 4,
  parameter logic [23:0] KEY_COLOR      = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        new_frame_in,
  input  logic [23:0] bg_rgb,
  input  logic [23:0] sprite0_rgb,
  input  logic [23:0] sprite1_rgb,
  input  logic [23:0] key_color_in,
  input  logic        key_update,
  output logic [7:0]  pixel_red,
  output logic [7:0]  pixel_green,
  output logic [7:0]  pixel_blue,
  output logic        active_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        collision,
  output logic        frame_done
);

  localparam int unsigned L = SPRITE_LATENCY;

  logic [L-1:0] act_dl_q, act_dl_d;
  logic [L-1:0] hs_dl_q,  hs_dl_d;
  logic [L-1:0] vs_dl_q,  vs_dl_d;
  logic [L-1:0] nf_dl_q,  nf_dl_d;
  logic [L:0]   act_ext,  hs_ext, vs_ext, nf_ext;

  logic [23:0]  rgb_q, rgb_d;
  logic         active_q, active_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         collision_q, collision_d;
  logic         frame_done_q, frame_done_d;
  logic [23:0]  key_q, key_d;
  logic [23:0]  pend_key_q, pend_key_d;
  logic         pend_q, pend_d;
  logic         acc_q, acc_d;
  logic         armed_q, armed_d;

  logic         a_d, h_d, v_d, nf_d;
  logic         opaque0, opaque1, overlap;

  assign act_ext = {act_dl_q, active_in};
  assign hs_ext  = {hs_dl_q, hsync_in};
  assign vs_ext  = {vs_dl_q, vsync_in};
  assign nf_ext  = {nf_dl_q, new_frame_in};

  assign a_d  = act_dl_q[L-1];
  assign h_d  = hs_dl_q[L-1];
  assign v_d  = vs_dl_q[L-1];
  assign nf_d = nf_dl_q[L-1];

  always_comb begin
    act_dl_d = act_ext[L-1:0];
    hs_dl_d  = hs_ext[L-1:0];
    vs_dl_d  = vs_ext[L-1:0];
    nf_dl_d  = nf_ext[L-1:0];

    opaque0 = (sprite0_rgb != key_q);
    opaque1 = (sprite1_rgb != key_q);
    overlap = a_d & opaque0 & opaque1;

    if (!a_d) begin
      rgb_d = 24'h000000;
    end else if (opaque0) begin
      rgb_d = sprite0_rgb;
    end else if (opaque1) begin
      rgb_d = sprite1_rgb;
    end else begin
      rgb_d = bg_rgb;
    end
    active_d = a_d;
    hsync_d  = h_d;
    vsync_d  = v_d;

    // The boundary pixel seeds the new frame's accumulator; nothing before the
    // first boundary after reset is reported.
    if (nf_d) begin
      collision_d  = armed_q & acc_q;
      frame_done_d = 1'b1;
      acc_d        = overlap;
      armed_d      = 1'b1;
    end else begin
      collision_d  = collision_q;
      frame_done_d = 1'b0;
      acc_d        = acc_q | overlap;
      armed_d      = armed_q;
    end

    key_d      = key_q;
    pend_key_d = pend_key_q;
    pend_d     = pend_q;
    if (nf_d && pend_q) begin
      key_d  = pend_key_q;
      pend_d = 1'b0;
    end else begin
      key_d  = key_q;
    end
    // A same-cycle update lands after the boundary has consumed the old pending key.
    if (key_update) begin
      pend_key_d = key_color_in;
      pend_d     = 1'b1;
    end else begin
      pend_key_d = pend_key_d;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      act_dl_q     <= '0;
      hs_dl_q      <= '0;
      vs_dl_q      <= '0;
      nf_dl_q      <= '0;
      rgb_q        <= 24'h000000;
      active_q     <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      collision_q  <= 1'b0;
      frame_done_q <= 1'b0;
      key_q        <= KEY_COLOR;
      pend_key_q   <= KEY_COLOR;
      pend_q       <= 1'b0;
      acc_q        <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      act_dl_q     <= act_dl_d;
      hs_dl_q      <= hs_dl_d;
      vs_dl_q      <= vs_dl_d;
      nf_dl_q      <= nf_dl_d;
      rgb_q        <= rgb_d;
      active_q     <= active_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      collision_q  <= collision_d;
      frame_done_q <= frame_done_d;
      key_q        <= key_d;
      pend_key_q   <= pend_key_d;
      pend_q       <= pend_d;
      acc_q        <= acc_d;
      armed_q      <= armed_d;
    end
  end

  assign pixel_red   = rgb_q[23:16];
  assign pixel_green = rgb_q[15:8];
  assign pixel_blue  = rgb_q[7:0];
  assign active_out  = active_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign collision   = collision_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed vectors plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_sprite_compositor;

  localparam int unsigned L = 4;
  localparam logic [23:0] KEY = 24'h000000;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic        active_in, hsync_in, vsync_in, new_frame_in;
  logic [23:0] bg_rgb, sprite0_rgb, sprite1_rgb, key_color_in;
  logic        key_update;
  logic [7:0]  pixel_red, pixel_green, pixel_blue;
  logic        active_out, hsync_out, vsync_out, collision, frame_done;

  int n_pass  = 0;
  int n_total = 0;

  sprite_compositor #(.SPRITE_LATENCY(L), .KEY_COLOR(KEY)) dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .active_in    (active_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .new_frame_in (new_frame_in),
    .bg_rgb       (bg_rgb),
    .sprite0_rgb  (sprite0_rgb),
    .sprite1_rgb  (sprite1_rgb),
    .key_color_in (key_color_in),
    .key_update   (key_update),
    .pixel_red    (pixel_red),
    .pixel_green  (pixel_green),
    .pixel_blue   (pixel_blue),
    .active_out   (active_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .collision    (collision),
    .frame_done   (frame_done)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Behavioural model state: timing history as a queue, key/collision as plain variables.
  logic [3:0]  tq[$];
  logic [23:0] m_key, m_pkey;
  logic        m_pend, m_acc, m_armed;
  logic [23:0] e_rgb;
  logic        e_act, e_hs, e_vs, e_coll, e_fd;

  typedef struct {
    logic        a;
    logic [23:0] s0;
    logic [23:0] s1;
    logic [23:0] bg;
    logic [23:0] exp_rgb;
  } prio_vec_t;
  prio_vec_t pv[5];

  function automatic logic [23:0] out_rgb();
    return {pixel_red, pixel_green, pixel_blue};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    tq.delete();
    for (int i = 0; i < L; i++) tq.push_back(4'b0000);
    m_key = KEY; m_pkey = KEY; m_pend = 1'b0; m_acc = 1'b0; m_armed = 1'b0;
    e_rgb = 24'h0; e_act = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_coll = 1'b0; e_fd = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] d;
    logic o0, o1, ov;
    d = tq.pop_front();
    tq.push_back({active_in, hsync_in, vsync_in, new_frame_in});
    o0 = (sprite0_rgb != m_key);
    o1 = (sprite1_rgb != m_key);
    if (!d[3])   e_rgb = 24'h0;
    else if (o0) e_rgb = sprite0_rgb;
    else if (o1) e_rgb = sprite1_rgb;
    else         e_rgb = bg_rgb;
    e_act = d[3]; e_hs = d[2]; e_vs = d[1];
    ov = d[3] & o0 & o1;
    e_fd = d[0];
    if (d[0]) begin
      e_coll  = m_armed ? m_acc : 1'b0;
      m_armed = 1'b1;
      m_acc   = ov;
      if (m_pend) begin
        m_key  = m_pkey;
        m_pend = 1'b0;
      end
    end else begin
      m_acc = m_acc | ov;
    end
    if (key_update) begin
      m_pkey = key_color_in;
      m_pend = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("rgb",        out_rgb(),             e_rgb);
    check("active_out", {23'b0, active_out},   {23'b0, e_act});
    check("hsync_out",  {23'b0, hsync_out},    {23'b0, e_hs});
    check("vsync_out",  {23'b0, vsync_out},    {23'b0, e_vs});
    check("collision",  {23'b0, collision},    {23'b0, e_coll});
    check("frame_done", {23'b0, frame_done},   {23'b0, e_fd});
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    if (rst) model_step();
    #1;
    compare_all();
  endtask

  // After this, the next tick is the edge on which the delayed frame pulse is seen.
  task automatic boundary();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    repeat (L - 1) tick();
  endtask

  function automatic logic [23:0] pick_color();
    logic [23:0] r;
    r = 24'($urandom);
    case ($urandom_range(0, 4))
      0:       return 24'h000000;
      1:       return 24'hFF0000;
      2:       return 24'h00FF00;
      3:       return 24'h0000FF;
      default: return r;
    endcase
  endfunction

  initial begin
    pv[0] = '{1'b1, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000};
    pv[1] = '{1'b1, 24'h000000, 24'h00FF00, 24'h0000FF, 24'h00FF00};
    pv[2] = '{1'b1, 24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF};
    pv[3] = '{1'b0, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000};
    pv[4] = '{1'b1, 24'h000000, 24'hABCDEF, 24'h0000FF, 24'hABCDEF};

    rst = 1'b0;
    active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; new_frame_in = 1'b0;
    bg_rgb = 24'h0; sprite0_rgb = 24'h0; sprite1_rgb = 24'h0;
    key_color_in = 24'h0; key_update = 1'b0;
    model_reset();
    #12;
    compare_all();
    rst = 1'b1;
    repeat (5) tick();

    // Latency: timing at edge E, pixels at edge E+L, outputs visible after E+L.
    active_in = 1'b1; hsync_in = 1'b1;
    tick();
    active_in = 1'b0; hsync_in = 1'b0;
    repeat (L - 1) tick();
    check("lat_early_active", {23'b0, active_out}, 24'h0);
    bg_rgb = 24'h123456;
    tick();
    check("lat_active", {23'b0, active_out}, 24'h1);
    check("lat_hsync",  {23'b0, hsync_out},  24'h1);
    check("lat_rgb",    out_rgb(),           24'h123456);
    bg_rgb = 24'h0;
    tick();

    // Priority table.
    for (int i = 0; i < 5; i++) begin
      active_in = pv[i].a;
      sprite0_rgb = pv[i].s0; sprite1_rgb = pv[i].s1; bg_rgb = pv[i].bg;
      repeat (L + 1) tick();
      check("prio", out_rgb(), pv[i].exp_rgb);
    end

    // Key change takes effect only after the boundary pixel.
    active_in = 1'b1;
    sprite0_rgb = 24'hFF00FF; sprite1_rgb = 24'hFF00FF; bg_rgb = 24'h000011;
    repeat (L + 1) tick();
    key_color_in = 24'hFF00FF; key_update = 1'b1;
    tick();
    key_update = 1'b0;
    tick();
    check("key_before", out_rgb(), 24'hFF00FF);
    boundary();
    tick();
    check("key_nf_pixel", out_rgb(), 24'hFF00FF);
    tick();
    check("key_after", out_rgb(), 24'h000011);

    // Two updates in a frame: last one wins.
    key_color_in = 24'h00FF00; key_update = 1'b1;
    tick();
    key_color_in = 24'h0000FF;
    tick();
    key_update = 1'b0;
    sprite0_rgb = 24'h0000FF; sprite1_rgb = 24'h00FF00; bg_rgb = 24'h000022;
    tick();
    check("two_upd_before", out_rgb(), 24'h0000FF);
    boundary();
    tick();
    tick();
    check("two_upd_applied", out_rgb(), 24'h00FF00);

    // Update coinciding with the boundary: old pending applied, new one stays pending.
    key_color_in = 24'h111111; key_update = 1'b1;
    tick();
    key_update = 1'b0;
    boundary();
    key_color_in = 24'h222222; key_update = 1'b1;
    tick();
    key_update = 1'b0;
    sprite0_rgb = 24'h111111; sprite1_rgb = 24'h222222; bg_rgb = 24'h000033;
    tick();
    check("kupd_nf_old", out_rgb(), 24'h222222);
    boundary();
    tick();
    tick();
    check("kupd_nf_new", out_rgb(), 24'h111111);
    key_color_in = 24'h000000; key_update = 1'b1;
    tick();
    key_update = 1'b0;
    sprite0_rgb = 24'h0; sprite1_rgb = 24'h0; bg_rgb = 24'h000055;
    boundary();
    tick();
    tick();

    // Collision across frames.
    boundary();
    tick();
    tick();
    sprite0_rgb = 24'hFFFFFF; sprite1_rgb = 24'hFFFFFF;
    tick();
    sprite0_rgb = 24'h0; sprite1_rgb = 24'h0;
    repeat (3) tick();
    boundary();
    tick();
    check("coll_set",  {23'b0, collision},  24'h1);
    check("coll_fd",   {23'b0, frame_done}, 24'h1);
    tick();
    check("coll_fd_pulse", {23'b0, frame_done}, 24'h0);
    check("coll_hold",     {23'b0, collision},  24'h1);
    repeat (3) tick();
    boundary();
    tick();
    check("coll_clear",    {23'b0, collision},  24'h0);
    check("coll_clear_fd", {23'b0, frame_done}, 24'h1);

    // Overlap during blanking is ignored.
    active_in = 1'b0;
    repeat (L) tick();
    sprite0_rgb = 24'hFFFFFF; sprite1_rgb = 24'hFFFFFF;
    repeat (2) tick();
    sprite0_rgb = 24'h0; sprite1_rgb = 24'h0;
    active_in = 1'b1;
    boundary();
    tick();
    check("coll_inactive", {23'b0, collision}, 24'h0);

    // Overlap on the boundary pixel belongs to the new frame.
    boundary();
    sprite0_rgb = 24'hFFFFFF; sprite1_rgb = 24'hFFFFFF;
    tick();
    check("bnd_ovl_now", {23'b0, collision}, 24'h0);
    sprite0_rgb = 24'h0; sprite1_rgb = 24'h0;
    repeat (2) tick();
    boundary();
    tick();
    check("bnd_ovl_next", {23'b0, collision}, 24'h1);

    // Reset mid-frame with a non-default key and collision set.
    hsync_in = 1'b1; vsync_in = 1'b1;
    key_color_in = 24'h555555; key_update = 1'b1;
    tick();
    key_update = 1'b0;
    sprite0_rgb = 24'hFFFFFF; sprite1_rgb = 24'hFFFFFF; bg_rgb = 24'h000044;
    tick();
    boundary();
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("rst_rgb",    out_rgb(),            24'h0);
    check("rst_active", {23'b0, active_out},  24'h0);
    check("rst_hsync",  {23'b0, hsync_out},   24'h0);
    check("rst_vsync",  {23'b0, vsync_out},   24'h0);
    check("rst_coll",   {23'b0, collision},   24'h0);
    check("rst_fd",     {23'b0, frame_done},  24'h0);
    model_reset();
    repeat (2) tick();
    #3;
    rst = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0;
    sprite0_rgb = 24'h0; sprite1_rgb = 24'h0; bg_rgb = 24'h000044;
    repeat (L + 1) tick();
    check("rst_key", out_rgb(), 24'h000044);
    boundary();
    tick();
    check("rst_first_coll", {23'b0, collision},  24'h0);
    check("rst_first_fd",   {23'b0, frame_done}, 24'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      active_in    = ($urandom_range(0, 3) != 0);
      hsync_in     = 1'($urandom);
      vsync_in     = 1'($urandom);
      new_frame_in = ($urandom_range(0, 39) == 0);
      key_update   = ($urandom_range(0, 29) == 0);
      key_color_in = pick_color();
      sprite0_rgb  = pick_color();
      sprite1_rgb  = pick_color();
      bg_rgb       = 24'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
Downstream of the sprite pixel generators. Merges two sprite pixel streams over a background pixel stream into the final RGB pixel, using a chroma-key transparency colour and fixed layer priority (sprite0 over sprite1 over background). Delays the video timing signals to match the sprite pipeline latency. Detects per-frame sprite overlap and reports it for game logic.

Parameters:
SPRITE_LATENCY, 4, cycles from h_count/v_count presented to the sprites until their pixel is valid; depth of the timing delay line (1..8).
KEY_COLOR, 24'h000000, reset value of the transparency key; sprites output 0 outside their bounds, so black is transparent by default.

Ports:
pixel_clk  input  1  pixel clock
rst  input  1  asynchronous, active-low reset
active_in  input  1  active-video flag, aligned with the h_count/v_count sent to the sprites
hsync_in  input  1  horizontal sync, same alignment
vsync_in  input  1  vertical sync, same alignment
new_frame_in  input  1  one-cycle pulse on the first pixel of a frame, same alignment
bg_rgb  input  24  background pixel {R,G,B}, valid SPRITE_LATENCY cycles after its timing
sprite0_rgb  input  24  top-priority sprite pixel, same alignment as bg_rgb
sprite1_rgb  input  24  second-priority sprite pixel, same alignment as bg_rgb
key_color_in  input  24  new transparency key
key_update  input  1  pulse; captures key_color_in as the pending key
pixel_red  output  8  composited red
pixel_green  output  8  composited green
pixel_blue  output  8  composited blue
active_out  output  1  delayed active_in
hsync_out  output  1  delayed hsync_in
vsync_out  output  1  delayed vsync_in
collision  output  1  1 if sprite0 and sprite1 were both opaque on some active pixel of the last completed frame
frame_done  output  1  one-cycle pulse when collision is updated

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; delay line cleared to 0; active key and pending key = KEY_COLOR; pending flag, overlap accumulator and collision = 0.
- Delay line: active/hsync/vsync/new_frame each pass through a SPRITE_LATENCY-stage shift register, giving a_d, h_d, v_d and nf_d, which align with the pixel inputs.
- Compose stage (one register): opaqueN = (spriteN_rgb != active key).
  - Selected colour = sprite0 if opaque0, else sprite1 if opaque1, else bg_rgb.
  - Output = selected colour if a_d=1, else 24'h0.
  - active_out/hsync_out/vsync_out register a_d/h_d/v_d in the same cycle, so they stay aligned with the RGB outputs.
- Total latency: timing input to timing output = SPRITE_LATENCY+1 cycles; pixel inputs to RGB outputs = 1 cycle.
- Key update: on key_update=1, pending key <= key_color_in and pending flag <= 1. A later key_update before the frame boundary overwrites the pending key (last write wins).
  - On a cycle with nf_d=1 and pending flag set, active key <= pending key and the flag clears. The new key takes effect from the next cycle, so the pixel carrying nf_d still uses the old key.
  - key_update and nf_d in the same cycle: the frame boundary applies the old pending value, if one exists. The new value becomes pending and the flag stays 1.
- Overlap accumulator: acc <= acc | (a_d & opaque0 & opaque1) on every cycle except nf_d cycles.
  - On nf_d=1: collision <= acc, frame_done <= 1 for exactly one cycle, and acc <= (a_d & opaque0 & opaque1), so the first pixel counts toward the new frame.
  - collision holds its value between boundaries.
- The first nf_d after reset reports collision=0.
- Reset mid-frame: everything returns to reset values immediately. No frame_done fires until the next nf_d after reset is released.

Test Plan:
- Latency: SPRITE_LATENCY=4. Pulse active_in=1 and hsync_in=1 at cycle 10, with bg_rgb=24'h123456 and sprites=0 presented at cycle 14 → active_out=1, hsync_out=1, RGB=12/34/56 all at cycle 15; all outputs 0 during reset.
- Priority: with a_d=1, sprite0=FF0000, sprite1=00FF00, bg=0000FF → FF0000. Then sprite0=0 → 00FF00. Then sprite1=0 → 0000FF. With a_d=0 → 000000 regardless of inputs.
- Key change: key_update with key_color_in=FF00FF mid-frame; sprite0=FF00FF.
  - Before the next nf_d, the output shows FF00FF.
  - On the nf_d pixel itself, the output still shows FF00FF (old key).
  - From the following pixel, the bg colour shows through.
  - Two updates (00FF00 then 0000FF) within one frame → 0000FF applied.
- Collision: one active pixel with sprite0=sprite1=FFFFFF in frame 1 → at frame 2's nf_d, collision=1 and frame_done=1 for one cycle. Frame 2 with no overlap → collision=0 at frame 3's nf_d. Overlap only while a_d=0 → collision=0.
- Boundary overlap: overlap exactly on the nf_d pixel → counted for the new frame: collision=0 at that boundary, 1 at the next.
- Reset mid-frame: assert rst=0 after an overlap → collision, frame_done, RGB and sync outputs go to 0 asynchronously; the active key returns to KEY_COLOR; the first boundary after release reports collision=0.
